// File: rtl/grb_frame_source_if.sv
// -----------------------------------------------------------------------------
// grb_frame_source_if
// Bundles the signals of grb_frame_source apart from clk and reset:
//   write port    : wr_en, wr_addr, wr_grb      (fills the back bank)
//   frame control : num_leds, start, busy, frame_done
//   pixel stream  : grb_out, grb_valid, grb_ready, led_index (valid/ready)
// Modports:
//   master : the frame source (drives pixels and status)
//   slave  : the writer / consumer side (drives writes, start and grb_ready)
// -----------------------------------------------------------------------------
interface grb_frame_source_if #(
    parameter int IDXW = 3
);
    logic            wr_en;
    logic [IDXW-1:0] wr_addr;
    logic [23:0]     wr_grb;
    logic [IDXW:0]   num_leds;
    logic            start;
    logic [23:0]     grb_out;
    logic            grb_valid;
    logic            grb_ready;
    logic [IDXW-1:0] led_index;
    logic            busy;
    logic            frame_done;

    modport master (
        input  wr_en, wr_addr, wr_grb, num_leds, start, grb_ready,
        output grb_out, grb_valid, led_index, busy, frame_done
    );

    modport slave (
        output wr_en, wr_addr, wr_grb, num_leds, start, grb_ready,
        input  grb_out, grb_valid, led_index, busy, frame_done
    );
endinterface

// File: rtl/grb_frame_source.sv
// -----------------------------------------------------------------------------
// grb_frame_source
// Double-buffered pixel source for the WS2812B driver chain. Two banks of
// MAX_LEDS GRB words: the writer fills the back bank while the front bank is
// streamed one word per LED over a valid/ready handshake. A start request
// swaps the banks and sends min(num_leds, MAX_LEDS) pixels.
// Ports:
//   clk   : system clock (100 MHz)
//   reset : synchronous, active-high; clears state, outputs and both banks
//   bus   : grb_frame_source_if.master (write port, frame control, pixels)
// -----------------------------------------------------------------------------
module grb_frame_source #(
    parameter int MAX_LEDS = 8,
    parameter int IDXW     = 3
) (
    input  logic               clk,
    input  logic               reset,
    grb_frame_source_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, OFFER, DONE} stateE;

    localparam logic [IDXW:0] MAX_COUNT = (IDXW + 1)'(MAX_LEDS);
    localparam logic [IDXW:0] ONE       = (IDXW + 1)'(1);

    stateE           state;
    logic            bankSel;      // front bank; the back bank is !bankSel
    logic [IDXW:0]   idx;          // one bit wider than the address
    logic [IDXW:0]   nLat;         // pixel count latched at start
    logic [23:0]     mem [2][MAX_LEDS];

    logic [23:0]     grbOut;
    logic            grbValid;
    logic [IDXW-1:0] ledIndex;
    logic            busy;
    logic            frameDone;

    assign bus.grb_out    = grbOut;
    assign bus.grb_valid  = grbValid;
    assign bus.led_index  = ledIndex;
    assign bus.busy       = busy;
    assign bus.frame_done = frameDone;

    // NOTE: all state here is sequential, so every assignment in this block
    // is non-blocking; reads of bankSel/idx see the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bankSel   <= 1'b0;
            idx       <= '0;
            nLat      <= '0;
            grbOut    <= '0;
            grbValid  <= 1'b0;
            ledIndex  <= '0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            // NOTE: both banks must read back as zero after reset, so the
            // storage is built from resettable flops rather than a RAM macro.
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < MAX_LEDS; w++) begin
                    mem[b][w] <= '0;
                end
            end
        end else begin
            // Writes always target the pre-edge back bank. On the edge that
            // accepts a start this is the bank that becomes front, so the
            // word is part of the frame about to be sent.
            if (bus.wr_en) begin
                mem[!bankSel][bus.wr_addr] <= bus.wr_grb;
            end

            case (state)
                IDLE: begin
                    // A start with num_leds==0 is dropped without a swap.
                    if (bus.start && (bus.num_leds != '0)) begin
                        bankSel <= !bankSel;
                        nLat    <= (bus.num_leds > MAX_COUNT) ? MAX_COUNT
                                                              : bus.num_leds;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end

                FETCH: begin
                    grbOut   <= mem[bankSel][idx[IDXW-1:0]];
                    ledIndex <= idx[IDXW-1:0];
                    grbValid <= 1'b1;
                    state    <= OFFER;
                end

                OFFER: begin
                    if (grbValid && bus.grb_ready) begin
                        grbValid <= 1'b0;
                        if (idx == nLat - ONE) begin
                            frameDone <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx   <= idx + ONE;
                            state <= FETCH;
                        end
                    end
                end

                DONE: begin
                    frameDone <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
